apb_bridge_ctrl: RTL and testbench
==================================

# apb_bridge_ctrl

Parametrised AHB-to-APB bridge controller: the successor to the single-slave bridge FSM. It accepts one AHB transfer at a time from the AHB slave interface and decodes it to one of `NUM_SLV` APB slaves. It runs the APB SETUP/ACCESS protocol with wait-state support and maps `pslverr`, or an unmapped slave index, onto a two-cycle AHB ERROR response. It sits between the AHB slave interface registers and the APB peripheral fabric.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `NUM_SLV`, default 4: number of APB slaves, 1..16.
- `SLV_SEL_LSB`, default 28: LSB of the slave-select field in `haddr`. Field width is `SEL_W = max(1, clog2(NUM_SLV))`.
- `TIMEOUT`, default 16: ACCESS-state wait limit in cycles. Used only with `APB_TIMEOUT_EN`.

Ports:
- `hclk` in 1: clock. All logic is on the rising edge.
- `hreset` in 1: reset. Synchronous, active-low.
- `valid` in 1: AHB transfer request (HSEL·HTRANS NONSEQ/SEQ), qualified by `hready_out`.
- `haddr` in ADDR_W: AHB address.
- `hwrite` in 1: 1 = write.
- `hwdata` in DATA_W: AHB write data, valid in the cycle after the address phase.
- `hready_out` out 1: AHB ready.
- `hresp` out 2: 00 = OKAY, 01 = ERROR.
- `hrdata` out DATA_W: read data (registered).
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB write.
- `pwdata` out DATA_W: APB write data.
- `penable` out 1: APB enable.
- `psel` out NUM_SLV: one-hot APB select.
- `prdata` in NUM_SLV*DATA_W: slave `i` drives bits `[i*DATA_W +: DATA_W]`.
- `pready` in NUM_SLV: per-slave ready.
- `pslverr` in NUM_SLV: per-slave error.

## Operation
- States: `IDLE`, `WWAIT`, `SETUP`, `ACCESS`, `ERR1`, `ERR2`. The state register is 3 bits.
- Acceptance: a transfer is accepted only in `IDLE` when `valid=1`. On acceptance:
  - `haddr` and `hwrite` are latched.
  - The slave index `idx = haddr[SLV_SEL_LSB +: SEL_W]` is latched.
- Transitions from `IDLE`:
  - `idx >= NUM_SLV` → `ERR1`. No APB activity occurs.
  - Write → `WWAIT`.
  - Read → `SETUP`.
- `WWAIT`: latch `hwdata` into `pwdata`, then go to `SETUP`.
- `SETUP`: `psel[idx]=1`, `penable=0`, `paddr`/`pwrite` from the latches, then go to `ACCESS`.
- `ACCESS`: `psel[idx]=1`, `penable=1`. Only `pready[idx]`, `pslverr[idx]` and the `prdata` slice for `idx` are observed; all other slaves are ignored.
  - `pready[idx]=0`: stay in `ACCESS`. All APB outputs are held stable.
  - `pready[idx]=1`, `pslverr[idx]=0`: go to `IDLE`. On a read, capture `prdata` into `hrdata`.
  - `pready[idx]=1`, `pslverr[idx]=1`: go to `ERR1`. `hrdata` is not updated.
- `ERR1`: `hresp=01`, `hready_out=0`, go to `ERR2`.
- `ERR2`: `hresp=01`, `hready_out=1`, go to `IDLE`. `valid` is ignored in `ERR2`; the AHB master cancels its following transfer per the ERROR protocol.
- `hready_out` is 1 in `IDLE` and `ERR2`, and 0 in every other state.
- `hresp` is 00 except in `ERR1`/`ERR2`.
- `psel` is all-zero outside `SETUP`/`ACCESS`. `penable` is 1 only in `ACCESS`.
- `paddr`, `pwrite` and `pwdata` hold their last value in `IDLE`; they are not forced to zero.

## Timing
- Reset values: state `IDLE`, `hready_out=1`, `hresp=00`, `hrdata=0`, `paddr=0`, `pwrite=0`, `pwdata=0`, `penable=0`, `psel=0`, timeout counter 0.
- Reset mid-operation: at the next edge with `hreset=0`, all outputs take their reset values regardless of `pready`. An in-flight transfer is dropped.
- Read latency: accept at edge 0, `SETUP` at cycle 1, `ACCESS` at cycle 2. With zero wait states, `IDLE` with valid `hrdata` and `hready_out=1` occurs at cycle 3. Each wait state adds 1 cycle.
- Write latency: one more than read, because of `WWAIT`. `IDLE` occurs at cycle 4 with zero wait states.
- Back-to-back: a new request may be accepted in the same `IDLE` cycle in which the previous transfer's `hrdata` is presented.
- `hrdata` holds its value until the next successful read completes.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter of width `clog2(TIMEOUT+1)` clears on entry to `ACCESS` and increments each `ACCESS` cycle with `pready[idx]=0`.
  - When the count reaches `TIMEOUT` while `pready[idx]=0`, the next state is `ERR1` and `psel`/`penable` drop at that edge.
  - A `pready[idx]=1` in the same cycle takes priority over the timeout.
- `APB_TIMEOUT_EN` undefined: no counter exists, `ACCESS` waits indefinitely, and `TIMEOUT` is unused.

## Test plan
- Zero-wait read of slave 2:
  - Stimulus: `haddr=0x2000_0010`, `prdata` slice 2 = `0xCAFE_F00D`.
  - Required: `psel=0100`, `penable` high for 1 cycle, `hrdata=0xCAFE_F00D` with `hready_out=1` at cycle 3, `hresp=00`.
- Write to slave 1 with 3 wait states:
  - Stimulus: `haddr=0x1000_0004`, `hwdata=0x1234_5678`.
  - Required: `pwrite=1`, `pwdata=0x1234_5678` stable for 4 `ACCESS` cycles, `hready_out` returns high at cycle 7.
- `pslverr` on slave 0 read:
  - Required: `ERR1` (`hresp=01`, `hready_out=0`), then `ERR2` (`hresp=01`, `hready_out=1`), `hrdata` unchanged.
- `NUM_SLV=3`, access with `haddr=0x3000_0000`:
  - Required: no `psel` asserted, two-cycle ERROR response.
- Reset pulse during `ACCESS` with `pready=0`:
  - Required: next edge gives `psel=0`, `penable=0`, `hready_out=1`, state `IDLE`.
- `APB_TIMEOUT_EN`, `TIMEOUT=4`, `pready` held low:
  - Required: `ERR1` entered after 4 `ACCESS` cycles.
  - Without the macro: still in `ACCESS` at 100 cycles.

Source files
------------

// File: rtl/apb_bridge_ctrl_if.sv
// rtl/apb_bridge_ctrl_if.sv - AHB-side and APB-side bus bundle for apb_bridge_ctrl
interface apb_bridge_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      valid;
    logic [ADDR_W-1:0]         haddr;
    logic                      hwrite;
    logic [DATA_W-1:0]         hwdata;
    logic                      hready_out;
    logic [1:0]                hresp;
    logic [DATA_W-1:0]         hrdata;
    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic                      penable;
    logic [NUM_SLV-1:0]        psel;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;

    modport slave (
        input  valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        output hready_out, hresp, hrdata, paddr, pwrite, pwdata, penable, psel
    );

    modport master (
        output valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        input  hready_out, hresp, hrdata, paddr, pwrite, pwdata, penable, psel
    );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// rtl/apb_bridge_ctrl.sv - AHB-to-APB bridge FSM for NUM_SLV slaves; APB_TIMEOUT_EN adds an ACCESS wait limit
module apb_bridge_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 28,
    parameter int TIMEOUT     = 16
) (
    input  logic               hclk,
    input  logic               hreset,
    apb_bridge_ctrl_if.slave   bus
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_bridge_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [SEL_W-1:0]   idx_q;

    logic [SEL_W-1:0]   acc_idx;
    logic               acc_unmapped;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_cnt;
`endif

    function automatic logic [NUM_SLV-1:0] decode(input logic [SEL_W-1:0] i);
        decode = '0;
        for (int k = 0; k < NUM_SLV; k++)
            if (i == SEL_W'(k)) decode[k] = 1'b1;
    endfunction

    assign acc_idx      = bus.haddr[SLV_SEL_LSB +: SEL_W];
    assign acc_unmapped = ({1'b0, acc_idx} >= (SEL_W + 1)'(NUM_SLV));

    // Only the addressed slave's response is visible to the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ready = bus.pready[k];
                sel_err   = bus.pslverr[k];
                sel_rdata = bus.prdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset) begin
            state          <= IDLE;
            addr_q         <= '0;
            write_q        <= 1'b0;
            idx_q          <= '0;
            bus.hready_out <= 1'b1;
            bus.hresp      <= 2'b00;
            bus.hrdata     <= '0;
            bus.paddr      <= '0;
            bus.pwrite     <= 1'b0;
            bus.pwdata     <= '0;
            bus.penable    <= 1'b0;
            bus.psel       <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        addr_q         <= bus.haddr;
                        write_q        <= bus.hwrite;
                        idx_q          <= acc_idx;
                        bus.hready_out <= 1'b0;
                        if (acc_unmapped) begin
                            state     <= ERR1;
                            bus.hresp <= 2'b01;
                        end else if (bus.hwrite) begin
                            state <= WWAIT;
                        end else begin
                            state      <= SETUP;
                            bus.psel   <= decode(acc_idx);
                            bus.paddr  <= bus.haddr;
                            bus.pwrite <= 1'b0;
                        end
                    end
                end
                WWAIT: begin
                    state      <= SETUP;
                    bus.pwdata <= bus.hwdata;
                    bus.psel   <= decode(idx_q);
                    bus.paddr  <= addr_q;
                    bus.pwrite <= write_q;
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        bus.psel    <= '0;
                        bus.penable <= 1'b0;
                        if (sel_err) begin
                            state     <= ERR1;
                            bus.hresp <= 2'b01;
                        end else begin
                            state          <= IDLE;
                            bus.hready_out <= 1'b1;
                            if (!write_q) bus.hrdata <= sel_rdata;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                        // This wait cycle brings the count to TIMEOUT: abandon the transfer.
                        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                            state       <= ERR1;
                            bus.hresp   <= 2'b01;
                            bus.psel    <= '0;
                            bus.penable <= 1'b0;
                        end
                    end
`endif
                end
                ERR1: begin
                    state          <= ERR2;
                    bus.hready_out <= 1'b1;
                end
                ERR2: begin
                    state     <= IDLE;
                    bus.hresp <= 2'b00;
                end
                default: begin
                    state          <= IDLE;
                    bus.hready_out <= 1'b1;
                    bus.hresp      <= 2'b00;
                    bus.psel       <= '0;
                    bus.penable    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb/tb_apb_bridge_ctrl.sv - directed self-checking bench for apb_bridge_ctrl
module tb_apb_bridge_ctrl;
    logic hclk = 1'b0;
    logic hreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 hclk = ~hclk;

    apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) ifa ();
    apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) ifb ();

    apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SEL_LSB(28), .TIMEOUT(4))
        dut (.hclk(hclk), .hreset(hreset), .bus(ifa));

    apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_SEL_LSB(28), .TIMEOUT(4))
        dut3 (.hclk(hclk), .hreset(hreset), .bus(ifb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge hclk);
    endtask

    initial begin
        ifa.valid = 0; ifa.haddr = '0; ifa.hwrite = 0; ifa.hwdata = '0;
        ifa.prdata = {32'hAAAA_0003, 32'hCAFE_F00D, 32'hAAAA_0001, 32'h1111_1111};
        ifa.pready = 4'b0000; ifa.pslverr = 4'b0000;
        ifb.valid = 0; ifb.haddr = '0; ifb.hwrite = 0; ifb.hwdata = '0;
        ifb.prdata = '0; ifb.pready = 3'b111; ifb.pslverr = 3'b000;

        tick(); tick();
        chk("rst_hready", ifa.hready_out, 1);
        chk("rst_hresp", ifa.hresp, 0);
        chk("rst_hrdata", ifa.hrdata, 0);
        chk("rst_paddr", ifa.paddr, 0);
        chk("rst_pwdata", ifa.pwdata, 0);
        chk("rst_pwrite", ifa.pwrite, 0);
        chk("rst_psel", ifa.psel, 0);
        chk("rst_penable", ifa.penable, 0);
        hreset = 1;

        // Zero-wait read of slave 2; other slaves not ready and erroring.
        ifa.valid = 1; ifa.haddr = 32'h2000_0010; ifa.hwrite = 0;
        ifa.pready = 4'b0100; ifa.pslverr = 4'b1011;
        tick();  // cycle 1
        ifa.valid = 0;
        chk("rd_setup_psel", ifa.psel, 4'b0100);
        chk("rd_setup_penable", ifa.penable, 0);
        chk("rd_setup_hready", ifa.hready_out, 0);
        chk("rd_setup_paddr", ifa.paddr, 32'h2000_0010);
        tick();  // cycle 2
        chk("rd_access_penable", ifa.penable, 1);
        chk("rd_access_psel", ifa.psel, 4'b0100);
        tick();  // cycle 3
        chk("rd_done_hready", ifa.hready_out, 1);
        chk("rd_done_hrdata", ifa.hrdata, 32'hCAFE_F00D);
        chk("rd_done_hresp", ifa.hresp, 0);
        chk("rd_done_penable", ifa.penable, 0);
        chk("rd_done_psel", ifa.psel, 0);

        // Write slave 1 with 3 wait states.
        ifa.pready = 4'b0000; ifa.pslverr = 4'b0000;
        ifa.valid = 1; ifa.haddr = 32'h1000_0004; ifa.hwrite = 1;
        tick();  // cycle 1: WWAIT
        ifa.valid = 0; ifa.hwdata = 32'h1234_5678;
        chk("wr_wwait_hready", ifa.hready_out, 0);
        chk("wr_wwait_psel", ifa.psel, 0);
        tick();  // cycle 2: SETUP
        ifa.hwdata = 32'hDEAD_BEEF;
        chk("wr_setup_psel", ifa.psel, 4'b0010);
        chk("wr_setup_pwrite", ifa.pwrite, 1);
        chk("wr_setup_pwdata", ifa.pwdata, 32'h1234_5678);
        chk("wr_setup_paddr", ifa.paddr, 32'h1000_0004);
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk("wr_access_penable", ifa.penable, 1);
            chk("wr_access_psel", ifa.psel, 4'b0010);
            chk("wr_access_pwdata", ifa.pwdata, 32'h1234_5678);
            chk("wr_access_hready", ifa.hready_out, 0);
            if (c == 6) ifa.pready = 4'b0010;
        end
        tick();  // cycle 7
        chk("wr_done_hready", ifa.hready_out, 1);
        chk("wr_done_penable", ifa.penable, 0);
        chk("wr_done_hrdata_kept", ifa.hrdata, 32'hCAFE_F00D);
        chk("wr_done_pwdata_hold", ifa.pwdata, 32'h1234_5678);

        // Back-to-back read of slave 0 ending in pslverr.
        ifa.valid = 1; ifa.haddr = 32'h0000_0020; ifa.hwrite = 0;
        ifa.pready = 4'b0001; ifa.pslverr = 4'b0001;
        tick();
        ifa.valid = 0;
        chk("err_setup_psel", ifa.psel, 4'b0001);
        tick();
        chk("err_access_penable", ifa.penable, 1);
        tick();  // ERR1
        chk("err1_hresp", ifa.hresp, 2'b01);
        chk("err1_hready", ifa.hready_out, 0);
        chk("err1_psel", ifa.psel, 0);
        chk("err1_hrdata", ifa.hrdata, 32'hCAFE_F00D);
        ifa.valid = 1; ifa.haddr = 32'h2000_0000;
        tick();  // ERR2, valid must be ignored
        chk("err2_hresp", ifa.hresp, 2'b01);
        chk("err2_hready", ifa.hready_out, 1);
        ifa.valid = 0;
        tick();  // IDLE
        chk("err_idle_hready", ifa.hready_out, 1);
        chk("err_idle_hresp", ifa.hresp, 0);
        chk("err_idle_psel", ifa.psel, 0);

        // Reset during ACCESS with pready low.
        ifa.pready = 4'b0000; ifa.pslverr = 4'b0000;
        ifa.valid = 1; ifa.haddr = 32'h3000_0000; ifa.hwrite = 0;
        tick();
        ifa.valid = 0;
        tick();
        chk("rsta_penable", ifa.penable, 1);
        chk("rsta_psel", ifa.psel, 4'b1000);
        hreset = 0;
        tick();
        chk("rsta_psel_clr", ifa.psel, 0);
        chk("rsta_penable_clr", ifa.penable, 0);
        chk("rsta_hready", ifa.hready_out, 1);
        chk("rsta_hrdata", ifa.hrdata, 0);
        hreset = 1;

        // Unmapped slave index on the 3-slave instance.
        ifb.valid = 1; ifb.haddr = 32'h3000_0000; ifb.hwrite = 0;
        tick();
        ifb.valid = 0;
        chk("unm_err1_psel", ifb.psel, 0);
        chk("unm_err1_hresp", ifb.hresp, 2'b01);
        chk("unm_err1_hready", ifb.hready_out, 0);
        tick();
        chk("unm_err2_hresp", ifb.hresp, 2'b01);
        chk("unm_err2_hready", ifb.hready_out, 1);
        chk("unm_err2_psel", ifb.psel, 0);
        tick();
        chk("unm_idle_hresp", ifb.hresp, 0);
        chk("unm_idle_paddr", ifb.paddr, 0);

        // pready held low on slave 2.
        ifa.valid = 1; ifa.haddr = 32'h2000_0000; ifa.hwrite = 0;
        tick();  // cycle 1 SETUP
        ifa.valid = 0;
`ifdef APB_TIMEOUT_EN
        tick(); tick(); tick(); tick();  // ACCESS cycles 2..5
        chk("to_last_access_penable", ifa.penable, 1);
        tick();  // cycle 6
        chk("to_err1_hresp", ifa.hresp, 2'b01);
        chk("to_err1_hready", ifa.hready_out, 0);
        chk("to_err1_psel", ifa.psel, 0);
        chk("to_err1_penable", ifa.penable, 0);
`else
        for (int c = 0; c < 100; c++) tick();
        chk("noto_penable", ifa.penable, 1);
        chk("noto_psel", ifa.psel, 4'b0100);
        chk("noto_hready", ifa.hready_out, 0);
        chk("noto_hresp", ifa.hresp, 0);
`endif
        hreset = 0;
        tick();
        hreset = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
